fadd_pipe: RTL and testbench

- Pipelined IEEE-754 single-precision floating-point adder for the FPU datapath.
- Computes op1 + op2, where either operand may be negative, so it also performs subtraction.
- Accepts one operation per clock and returns the sum a fixed number of cycles later.
- No handshake; the surrounding pipeline tracks latency.

---
 rtl/fadd_pipe.sv | 195 +++++++++++++++++++
 tb/tb_fadd_pipe.sv | 112 +++++++++++
 2 files changed

// File: rtl/fadd_pipe.sv
// Three-stage pipelined binary32 adder: op1 + op2 with flush-to-zero for denormals.
// Define FADD_RNE_EN for round-to-nearest-even; otherwise results are truncated toward zero.
module fadd_pipe (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [31:0] result
);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++)
            if (v[i]) n = 5'(26 - i);
        return n;
    endfunction

    // Returns {carry, hidden, fraction}; a carry means the mantissa rolled over to 2.0.
`ifdef FADD_RNE_EN
    function automatic logic [24:0] round_mant(input logic [23:0] m, input logic [2:0] grs);
        logic inc;
        inc = grs[2] & (grs[1] | grs[0] | m[0]);
        return {1'b0, m} + {24'b0, inc};
    endfunction
`else
    function automatic logic [24:0] round_mant(input logic [23:0] m);
        return {1'b0, m};
    endfunction
`endif

    function automatic logic [31:0] pack(input logic s, input logic signed [9:0] e,
                                         input logic [22:0] f);
        if (e >= 10'sd255)
            return {s, 8'hFF, 23'b0};
        else if (e <= 10'sd0)
            return {s, 31'b0};
        else
            return {s, e[7:0], f};
    endfunction

    logic        s1, s2, nan1, nan2, inf1, inf2, swap;
    logic [30:0] mag1, mag2, mag_l, mag_s;
    logic        sign_l, special;
    logic [31:0] spec_val;

    assign s1   = op1[31];
    assign s2   = op2[31];
    assign nan1 = (&op1[30:23]) & (|op1[22:0]);
    assign nan2 = (&op2[30:23]) & (|op2[22:0]);
    assign inf1 = (&op1[30:23]) & ~(|op1[22:0]);
    assign inf2 = (&op2[30:23]) & ~(|op2[22:0]);
    assign mag1 = (op1[30:23] == 8'd0) ? 31'd0 : op1[30:0];
    assign mag2 = (op2[30:23] == 8'd0) ? 31'd0 : op2[30:0];
    assign swap = mag2 > mag1;

    always_comb begin
        mag_l    = swap ? mag2 : mag1;
        mag_s    = swap ? mag1 : mag2;
        sign_l   = swap ? s2 : s1;
        special  = 1'b0;
        spec_val = 32'd0;
        if (nan1 || nan2 || (inf1 && inf2 && (s1 != s2))) begin
            special  = 1'b1;
            spec_val = QNAN;
        end else if (inf1) begin
            special  = 1'b1;
            spec_val = {s1, 8'hFF, 23'b0};
        end else if (inf2) begin
            special  = 1'b1;
            spec_val = {s2, 8'hFF, 23'b0};
        end
    end

    // ---- stage 1 register: unpacked, ordered operands ----
    logic        sign_l_p0, eff_sub_p0, special_p0;
    logic [7:0]  exp_l_p0, diff_p0;
    logic [23:0] mant_l_p0, mant_s_p0;
    logic [31:0] spec_val_p0;

    always_ff @(posedge clk) begin
        if (reset) begin
            sign_l_p0   <= 1'b0;
            eff_sub_p0  <= 1'b0;
            special_p0  <= 1'b0;
            exp_l_p0    <= 8'd0;
            diff_p0     <= 8'd0;
            mant_l_p0   <= 24'd0;
            mant_s_p0   <= 24'd0;
            spec_val_p0 <= 32'd0;
        end else begin
            sign_l_p0   <= sign_l;
            eff_sub_p0  <= s1 ^ s2;
            special_p0  <= special;
            exp_l_p0    <= mag_l[30:23];
            diff_p0     <= mag_l[30:23] - mag_s[30:23];
            mant_l_p0   <= {|mag_l[30:23], mag_l[22:0]};
            mant_s_p0   <= {|mag_s[30:23], mag_s[22:0]};
            spec_val_p0 <= spec_val;
        end
    end

    logic [49:0] wide;
    logic [26:0] aligned;
    logic [27:0] sum_n;

    always_comb begin
        wide = {mant_s_p0, 26'b0} >> diff_p0;
        if (diff_p0 >= 8'd26)
            aligned = {26'b0, |mant_s_p0};
        else
            aligned = {wide[49:24], |wide[23:0]};
        // The ordering in stage 1 guarantees the subtraction never goes negative.
        if (eff_sub_p0)
            sum_n = {1'b0, mant_l_p0, 3'b0} - {1'b0, aligned};
        else
            sum_n = {1'b0, mant_l_p0, 3'b0} + {1'b0, aligned};
    end

    // ---- stage 2 register: raw mantissa sum with guard/round/sticky ----
    logic        sign_l_p1, eff_sub_p1, special_p1;
    logic [7:0]  exp_l_p1;
    logic [27:0] sum_p1;
    logic [31:0] spec_val_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            sign_l_p1   <= 1'b0;
            eff_sub_p1  <= 1'b0;
            special_p1  <= 1'b0;
            exp_l_p1    <= 8'd0;
            sum_p1      <= 28'd0;
            spec_val_p1 <= 32'd0;
        end else begin
            sign_l_p1   <= sign_l_p0;
            eff_sub_p1  <= eff_sub_p0;
            special_p1  <= special_p0;
            exp_l_p1    <= exp_l_p0;
            sum_p1      <= sum_n;
            spec_val_p1 <= spec_val_p0;
        end
    end

    logic [4:0]        lz;
    logic [26:0]       norm;
    logic signed [9:0] exp_n, exp_r;
    logic [24:0]       rnd;
    logic [22:0]       frac_r;
    logic [31:0]       res_n;

    always_comb begin
        lz = lzc27(sum_p1[26:0]);
        if (sum_p1[27]) begin
            norm  = {sum_p1[27:2], sum_p1[1] | sum_p1[0]};
            exp_n = $signed({2'b0, exp_l_p1}) + 10'sd1;
        end else begin
            norm  = sum_p1[26:0] << lz;
            exp_n = $signed({2'b0, exp_l_p1}) - $signed({5'b0, lz});
        end
`ifdef FADD_RNE_EN
        rnd = round_mant(norm[26:3], norm[2:0]);
`else
        rnd = round_mant(norm[26:3]);
`endif
        if (rnd[24]) begin
            frac_r = rnd[23:1];
            exp_r  = exp_n + 10'sd1;
        end else begin
            frac_r = rnd[22:0];
            exp_r  = exp_n;
        end
        // An all-zero sum from a subtraction is an exact cancellation and is always +0.
        if (special_p1)
            res_n = spec_val_p1;
        else if (sum_p1 == 28'd0)
            res_n = {sign_l_p1 & ~eff_sub_p1, 31'b0};
        else
            res_n = pack(sign_l_p1, exp_r, frac_r);
    end

`ifndef FADD_RNE_EN
    logic unused_grs;
    assign unused_grs = ^norm[2:0];
`endif

    // ---- stage 3 register: packed result ----
    always_ff @(posedge clk) begin
        if (reset)
            result <= 32'd0;
        else
            result <= res_n;
    end

endmodule

// File: tb/tb_fadd_pipe.sv
// Directed-vector bench for fadd_pipe: streams vectors back-to-back and checks reset flushing.
// Rounding expectations follow FADD_RNE_EN.
module tb_fadd_pipe;
    logic        clk;
    logic        reset;
    logic [31:0] op1, op2;
    logic [31:0] result;

    fadd_pipe dut (
        .clk    (clk),
        .reset  (reset),
        .op1    (op1),
        .op2    (op2),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FADD_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    localparam int NV = 26;
    logic [31:0] va [NV];
    logic [31:0] vb [NV];
    logic [31:0] ve [NV];
    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    initial begin
        va = '{32'h3F800000, 32'h3FC00000, 32'h40400000, 32'h3F800000, 32'h3F800000,
               32'h3F800000, 32'h7F7FFFFF, 32'h7F800000, 32'h7F800000, 32'h7FC00001,
               32'h3F800000, 32'hFF800000, 32'h00000000, 32'h80000000, 32'h00000000,
               32'h00000001, 32'h3F800000, 32'h00800000, 32'h40000000, 32'hC0400000,
               32'h7F7FFFFF, 32'h3F800001, 32'hFF800000, 32'h3F800000, 32'h40000000,
               32'h40400000};
        vb = '{32'h3F800000, 32'hBFC00000, 32'hBF800000, 32'h33800000, 32'h33800001,
               32'h33C00000, 32'h7F7FFFFF, 32'hFF800000, 32'h3F800000, 32'h3F800000,
               32'hFF800001, 32'hFF800000, 32'h3F800000, 32'h80000000, 32'h80000000,
               32'hBF800000, 32'hB3800000, 32'h80800001, 32'hBF800000, 32'h40000000,
               32'h73000000, 32'h33800000, 32'h7F7FFFFF, 32'h3F800000, 32'h40000000,
               32'hC0400000};
        ve = '{32'h40000000, 32'h00000000, 32'h40000000, 32'h3F800000,
               RNE ? 32'h3F800001 : 32'h3F800000,
               RNE ? 32'h3F800001 : 32'h3F800000,
               32'h7F800000, 32'h7FC00000, 32'h7F800000, 32'h7FC00000,
               32'h7FC00000, 32'hFF800000, 32'h3F800000, 32'h80000000, 32'h00000000,
               32'hBF800000, 32'h3F7FFFFF, 32'h80000000, 32'h3F800000, 32'hBF800000,
               RNE ? 32'h7F800000 : 32'h7F7FFFFF,
               RNE ? 32'h3F800002 : 32'h3F800001,
               32'hFF800000, 32'h40000000, 32'h40800000, 32'h00000000};

        // Reset with live operands must keep the output at zero.
        reset = 1'b1;
        op1   = 32'h3F800000;
        op2   = 32'h3F800000;
        repeat (4) @(negedge clk);
        check_val("reset", result, 32'h00000000);
        reset = 1'b0;

        // Stream every vector on consecutive edges; each result is due three negedges later.
        for (int i = 0; i < NV + 3; i++) begin
            @(negedge clk);
            if (i >= 3)
                check_val($sformatf("vec%0d_%h_%h", i - 3, va[i-3], vb[i-3]), result, ve[i-3]);
            if (i < NV) begin
                op1 = va[i];
                op2 = vb[i];
            end else begin
                op1 = 32'h0;
                op2 = 32'h0;
            end
        end

        // Reset in the middle of traffic discards in-flight work.
        op1 = 32'h3F800000;
        op2 = 32'h3F800000;
        @(negedge clk);
        op1   = 32'h40000000;
        op2   = 32'h40000000;
        reset = 1'b1;
        @(negedge clk);
        check_val("in_reset", result, 32'h00000000);
        reset = 1'b0;
        op1   = 32'h40400000;
        op2   = 32'h3F800000;
        @(negedge clk);
        op1 = 32'h0;
        op2 = 32'h0;
        check_val("rst_flush0", result, 32'h00000000);
        @(negedge clk);
        check_val("rst_flush1", result, 32'h00000000);
        @(negedge clk);
        check_val("after_rst", result, 32'h40800000);
        @(negedge clk);
        check_val("after_rst_zero", result, 32'h00000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
